// File: rtl/alu_pkg.sv
// Shared widths, command encodings and operand-requirement decode for the registered ALU.
package alu_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    ArAdd, ArSub, ArAddCin, ArSubCin, ArIncA, ArDecA,
    ArIncB, ArDecB, ArCmp, ArMulInc, ArMulShl
  } arith_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    LgAnd, LgNand, LgOr, LgNor, LgXor, LgXnor, LgNotA,
    LgNotB, LgShrA, LgShlA, LgShrB, LgShlB, LgRolA, LgRorA
  } logic_cmd_e;

  // Required INP_VALID mask; 2'b00 marks a command undefined for that mode.
  function automatic logic [1:0] needs_ops(input logic mode, input logic [CMD_W-1:0] cmd);
    logic [1:0] need;
    need = 2'b00;
    if (mode) begin
      case (cmd)
        ArIncA, ArDecA: need = 2'b01;
        ArIncB, ArDecB: need = 2'b10;
        ArAdd, ArSub, ArAddCin, ArSubCin, ArCmp, ArMulInc, ArMulShl: need = 2'b11;
        default: need = 2'b00;
      endcase
    end else begin
      case (cmd)
        LgNotA, LgShrA, LgShlA: need = 2'b01;
        LgNotB, LgShrB, LgShlB: need = 2'b10;
        LgAnd, LgNand, LgOr, LgNor, LgXor, LgXnor, LgRolA, LgRorA: need = 2'b11;
        default: need = 2'b00;
      endcase
    end
    return need;
  endfunction

endpackage

// File: rtl/alu_mult_stage.sv
// Two-cycle multiplier: captures the product on start, presents it during the busy cycle.
module alu_mult_stage
  import alu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ce_i,
  input  logic           start_i,
  input  logic           shift_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic [2*N-1:0] prod_o
);

  localparam int unsigned W = 2 * N;

  logic         busy_q, busy_d;
  logic [W-1:0] prod_q, prod_d;
  logic [N:0]   a_inc, b_inc;
  logic [N-1:0] a_shl;

  always_comb begin
    a_inc  = {1'b0, a_i} + (N+1)'(1);
    b_inc  = {1'b0, b_i} + (N+1)'(1);
    a_shl  = a_i << 1;
    busy_d = busy_q;
    prod_d = prod_q;
    if (ce_i) begin
      if (busy_q) begin
        busy_d = 1'b0;
      end else if (start_i) begin
        busy_d = 1'b1;
        // (A+1)*(B+1) can reach 2^(2N); the result register keeps the low 2N bits.
        prod_d = shift_i ? W'(a_shl) * W'(b_i) : W'(a_inc) * W'(b_inc);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      prod_q <= '0;
    end else begin
      busy_q <= busy_d;
      prod_q <= prod_d;
    end
  end

  assign busy_o = busy_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU: combinational command decode feeding a single output register bank.
module alu_core
  import alu_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             MODE,
  input  logic [CMD_W-1:0] CMD,
  input  logic [1:0]       INP_VALID,
  input  logic [N-1:0]     OPA,
  input  logic [N-1:0]     OPB,
  input  logic             CIN,
  output logic [2*N-1:0]   RES,
  output logic             COUT,
  output logic             OFLOW,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic             ERR
);

  localparam int unsigned W = 2 * N;

  logic [W-1:0] res_q, res_d, op_res, mult_prod, rot;
  logic         cout_q, cout_d, oflow_q, oflow_d, g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d;
  logic         op_cout, op_oflow, op_g, op_l, op_e, op_err;
  logic         mult_req, mult_shift, mult_busy;
  logic [1:0]   need;
  logic [N:0]   sum;
  logic [N-1:0] lres;

  always_comb begin
    op_res = '0; op_cout = 1'b0; op_oflow = 1'b0;
    op_g = 1'b0; op_l = 1'b0; op_e = 1'b0; op_err = 1'b0;
    mult_req = 1'b0; mult_shift = 1'b0;
    sum = '0; lres = '0; rot = '0;
    need = needs_ops(MODE, CMD);
    if (need == 2'b00 || (INP_VALID & need) != need) begin
      op_err = 1'b1;
    end else if (MODE) begin
      case (arith_cmd_e'(CMD))
        ArAdd:    begin sum = {1'b0, OPA} + {1'b0, OPB}; op_res = W'(sum); op_cout = sum[N]; end
        ArSub:    begin op_res = W'(OPA) - W'(OPB); op_oflow = (OPA < OPB); end
        ArAddCin: begin
          sum     = {1'b0, OPA} + {1'b0, OPB} + (N+1)'(CIN);
          op_res  = W'(sum);
          op_cout = sum[N];
        end
        ArSubCin: begin
          op_res   = W'(OPA) - W'(OPB) - W'(CIN);
          op_oflow = ({1'b0, OPA} < ({1'b0, OPB} + (N+1)'(CIN)));
        end
        ArIncA:   begin sum = {1'b0, OPA} + (N+1)'(1); op_res = W'(sum); op_cout = sum[N]; end
        ArDecA:   begin op_res = W'(OPA) - W'(1); op_oflow = (OPA == '0); end
        ArIncB:   begin sum = {1'b0, OPB} + (N+1)'(1); op_res = W'(sum); op_cout = sum[N]; end
        ArDecB:   begin op_res = W'(OPB) - W'(1); op_oflow = (OPB == '0); end
        ArCmp:    begin op_g = (OPA > OPB); op_l = (OPA < OPB); op_e = (OPA == OPB); end
        ArMulInc: mult_req = 1'b1;
        ArMulShl: begin mult_req = 1'b1; mult_shift = 1'b1; end
        default:  op_err = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(CMD))
        LgAnd:   lres = OPA & OPB;
        LgNand:  lres = ~(OPA & OPB);
        LgOr:    lres = OPA | OPB;
        LgNor:   lres = ~(OPA | OPB);
        LgXor:   lres = OPA ^ OPB;
        LgXnor:  lres = ~(OPA ^ OPB);
        LgNotA:  lres = ~OPA;
        LgNotB:  lres = ~OPB;
        LgShrA:  lres = OPA >> 1;
        LgShlA:  lres = OPA << 1;
        LgShrB:  lres = OPB >> 1;
        LgShlB:  lres = OPB << 1;
        // Rotate via a doubled operand so the wrapped bits fall into the kept half.
        LgRolA:  begin rot = {OPA, OPA} << OPB[2:0]; lres = rot[W-1:N]; end
        LgRorA:  begin rot = {OPA, OPA} >> OPB[2:0]; lres = rot[N-1:0]; end
        default: lres = '0;
      endcase
      if ((CMD == LgRolA || CMD == LgRorA) && (|OPB[N-1:3])) begin
        op_err = 1'b1;
      end else begin
        op_res = W'(lres);
      end
    end
  end

  alu_mult_stage u_mult (
    .clk_i   (CLK),
    .rst_i   (RST),
    .ce_i    (CE),
    .start_i (mult_req),
    .shift_i (mult_shift),
    .a_i     (OPA),
    .b_i     (OPB),
    .busy_o  (mult_busy),
    .prod_o  (mult_prod)
  );

  always_comb begin
    res_d = res_q; cout_d = cout_q; oflow_d = oflow_q;
    g_d = g_q; l_d = l_q; e_d = e_q; err_d = err_q;
    if (CE) begin
      if (mult_busy) begin
        // Busy cycle: inputs ignored, the captured product is written with clear flags.
        res_d = mult_prod; cout_d = 1'b0; oflow_d = 1'b0;
        g_d = 1'b0; l_d = 1'b0; e_d = 1'b0; err_d = 1'b0;
      end else begin
        res_d = op_res; cout_d = op_cout; oflow_d = op_oflow;
        g_d = op_g; l_d = op_l; e_d = op_e; err_d = op_err;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0;
      g_q <= 1'b0; l_q <= 1'b0; e_q <= 1'b0; err_q <= 1'b0;
    end else begin
      res_q <= res_d; cout_q <= cout_d; oflow_q <= oflow_d;
      g_q <= g_d; l_q <= l_d; e_q <= e_d; err_q <= err_d;
    end
  end

  assign RES   = res_q;
  assign COUT  = cout_q;
  assign OFLOW = oflow_q;
  assign G     = g_q;
  assign L     = l_q;
  assign E     = e_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors plus randomized traffic against a reference model.
module tb_alu_core;

  logic        CLK, RST, CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, L, E, ERR;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] res;
    logic cout; logic oflow; logic g; logic l; logic e; logic err;
  } out_t;

  typedef struct {
    bit mode; int cmd; bit [1:0] iv; int a; int b; bit cin; out_t exp;
  } vec_t;

  alu_core dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
    .G(G), .L(L), .E(E), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic out_t observed();
    return {RES, COUT, OFLOW, G, L, E, ERR};
  endfunction

  function automatic bit is_mult(input bit mode, input int cmd);
    return mode && (cmd == 9 || cmd == 10);
  endfunction

  // Reference model: final registered outputs of one command (for multiplies, the product).
  function automatic out_t model(input bit mode, input int cmd, input bit [1:0] iv,
                                 input int a, input int b, input bit cin);
    out_t o; int need; int r; int s; bit [7:0] a8; bit [7:0] b8;
    o = '0; a8 = 8'(a); b8 = 8'(b); s = b;
    if (mode) need = (cmd == 4 || cmd == 5) ? 1 : (cmd == 6 || cmd == 7) ? 2 : (cmd <= 10) ? 3 : 0;
    else      need = (cmd == 6 || cmd == 8 || cmd == 9) ? 1 :
                     (cmd == 7 || cmd == 10 || cmd == 11) ? 2 : (cmd <= 13) ? 3 : 0;
    if (need == 0 || (int'(iv) & need) != need) begin
      o.err = 1'b1;
      return o;
    end
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;       o.res = 16'(r); o.cout = (r > 255); end
        1:  begin o.res = 16'(a - b);            o.oflow = (a < b); end
        2:  begin r = a + b + cin; o.res = 16'(r); o.cout = (r > 255); end
        3:  begin o.res = 16'(a - b - cin);      o.oflow = (a < b + cin); end
        4:  begin r = a + 1;       o.res = 16'(r); o.cout = (r > 255); end
        5:  begin o.res = 16'(a - 1);            o.oflow = (a == 0); end
        6:  begin r = b + 1;       o.res = 16'(r); o.cout = (r > 255); end
        7:  begin o.res = 16'(b - 1);            o.oflow = (b == 0); end
        8:  begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
        9:  o.res = 16'((a + 1) * (b + 1));
        default: o.res = 16'(((2 * a) % 256) * b);
      endcase
    end else begin
      case (cmd)
        0:  o.res = {8'h00, a8 & b8};
        1:  o.res = {8'h00, ~(a8 & b8)};
        2:  o.res = {8'h00, a8 | b8};
        3:  o.res = {8'h00, ~(a8 | b8)};
        4:  o.res = {8'h00, a8 ^ b8};
        5:  o.res = {8'h00, ~(a8 ^ b8)};
        6:  o.res = {8'h00, ~a8};
        7:  o.res = {8'h00, ~b8};
        8:  o.res = 16'(a / 2);
        9:  o.res = 16'((a * 2) % 256);
        10: o.res = 16'(b / 2);
        11: o.res = 16'((b * 2) % 256);
        12: if (b > 7) o.err = 1'b1; else o.res = 16'(((a << s) | (a >> (8 - s))) & 255);
        default: if (b > 7) o.err = 1'b1; else o.res = 16'(((a >> s) | (a << (8 - s))) & 255);
      endcase
    end
    return o;
  endfunction

  task automatic drive(input bit mode, input int cmd, input bit [1:0] iv,
                       input int a, input int b, input bit cin);
    MODE = mode; CMD = 4'(cmd); INP_VALID = iv; OPA = 8'(a); OPB = 8'(b); CIN = cin;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    out_t got; out_t held;
    RST = 1'b1; CE = 1'b0;
    drive(1, 0, 2'b11, 255, 1, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL reset_clear: got %h want %h", got, 22'h0); end
    RST = 1'b0; CE = 1'b0;
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL ce0_hold_zero: got %h want %h", got, 22'h0); end
    CE = 1'b1;
    tick();
    held = observed(); n_cmp++;
    if (held !== {16'h0100, 6'b100000}) begin
      n_bad++; $display("FAIL first_add: got %h want %h", held, {16'h0100, 6'b100000});
    end
    CE = 1'b0;
    drive(1, 1, 2'b11, 3, 5, 1);
    tick(); tick();
    got = observed(); n_cmp++;
    if (got !== {16'h0100, 6'b100000}) begin
      n_bad++; $display("FAIL ce0_hold_value: got %h want %h", got, {16'h0100, 6'b100000});
    end
    RST = 1'b1; CE = 1'b1;
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL rst_over_ce: got %h want %h", got, 22'h0); end
    RST = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v [$]; out_t got;
    v.push_back('{1'b1, 0,  2'b11, 8'hFF, 8'h01, 1'b0, out_t'({16'h0100, 6'b100000})});
    v.push_back('{1'b1, 1,  2'b11, 3,     5,     1'b0, out_t'({16'hFFFE, 6'b010000})});
    v.push_back('{1'b1, 8,  2'b11, 7,     7,     1'b0, out_t'({16'h0000, 6'b000010})});
    v.push_back('{1'b1, 8,  2'b11, 9,     2,     1'b0, out_t'({16'h0000, 6'b001000})});
    v.push_back('{1'b1, 8,  2'b11, 2,     9,     1'b0, out_t'({16'h0000, 6'b000100})});
    v.push_back('{1'b0, 12, 2'b11, 8'h81, 1,     1'b0, out_t'({16'h0003, 6'b000000})});
    v.push_back('{1'b0, 12, 2'b11, 8'h81, 8'h10, 1'b0, out_t'({16'h0000, 6'b000001})});
    v.push_back('{1'b0, 13, 2'b11, 8'h01, 1,     1'b0, out_t'({16'h0080, 6'b000000})});
    v.push_back('{1'b0, 0,  2'b01, 8'hFF, 8'hFF, 1'b0, out_t'({16'h0000, 6'b000001})});
    v.push_back('{1'b1, 4,  2'b01, 8'hFF, 0,     1'b0, out_t'({16'h0100, 6'b100000})});
    v.push_back('{1'b1, 15, 2'b11, 1,     1,     1'b0, out_t'({16'h0000, 6'b000001})});
    v.push_back('{1'b1, 5,  2'b01, 0,     0,     1'b0, out_t'({16'hFFFF, 6'b010000})});
    v.push_back('{1'b1, 3,  2'b11, 5,     5,     1'b1, out_t'({16'hFFFF, 6'b010000})});
    v.push_back('{1'b1, 2,  2'b11, 8'hFF, 8'hFF, 1'b1, out_t'({16'h01FF, 6'b100000})});
    v.push_back('{1'b0, 14, 2'b11, 1,     1,     1'b0, out_t'({16'h0000, 6'b000001})});
    v.push_back('{1'b0, 1,  2'b11, 8'hF0, 8'h3C, 1'b0, out_t'({16'h00CF, 6'b000000})});
    v.push_back('{1'b1, 6,  2'b10, 0,     8'hFF, 1'b0, out_t'({16'h0100, 6'b100000})});
    v.push_back('{1'b0, 9,  2'b01, 8'hC1, 0,     1'b0, out_t'({16'h0082, 6'b000000})});
    v.push_back('{1'b1, 8,  2'b00, 4,     4,     1'b0, out_t'({16'h0000, 6'b000001})});
    v.push_back('{1'b1, 7,  2'b10, 0,     5,     1'b0, out_t'({16'h0004, 6'b000000})});
    CE = 1'b1;
    foreach (v[i]) begin
      drive(v[i].mode, v[i].cmd, v[i].iv, v[i].a, v[i].b, v[i].cin);
      tick();
      got = observed(); n_cmp++;
      if (got !== v[i].exp) begin
        n_bad++;
        $display("FAIL directed[%0d] mode=%0d cmd=%0d: got %h want %h",
                 i, v[i].mode, v[i].cmd, got, v[i].exp);
      end
    end
  endtask

  task automatic test_mult();
    out_t got;
    CE = 1'b1;
    drive(1, 9, 2'b11, 3, 4, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL mul_inc_stage1: got %h want %h", got, 22'h0); end
    drive(1, 0, 2'b11, 200, 100, 1);
    tick();
    got = observed(); n_cmp++;
    if (got !== {16'd20, 6'b0}) begin
      n_bad++; $display("FAIL mul_inc_product: got %h want %h", got, {16'd20, 6'b0});
    end
    drive(1, 10, 2'b11, 8'h81, 2, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL mul_shl_stage1: got %h want %h", got, 22'h0); end
    drive(1, 10, 2'b11, 8'h7F, 8'hFF, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== {16'd4, 6'b0}) begin
      n_bad++; $display("FAIL mul_shl_product: got %h want %h", got, {16'd4, 6'b0});
    end
    // CE gap during the busy cycle stretches the multiply.
    drive(1, 9, 2'b11, 4, 5, 0);
    tick();
    CE = 1'b0;
    drive(1, 0, 2'b11, 1, 1, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL mul_ce_gap_hold: got %h want %h", got, 22'h0); end
    CE = 1'b1;
    tick();
    got = observed(); n_cmp++;
    if (got !== {16'd30, 6'b0}) begin
      n_bad++; $display("FAIL mul_ce_gap_product: got %h want %h", got, {16'd30, 6'b0});
    end
    // Reset mid-multiply must discard the pending product.
    drive(1, 9, 2'b11, 10, 10, 0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(1, 8, 2'b11, 7, 7, 0);
    tick();
    got = observed(); n_cmp++;
    if (got !== {16'd0, 6'b000010}) begin
      n_bad++; $display("FAIL mul_reset_abort: got %h want %h", got, {16'd0, 6'b000010});
    end
  endtask

  task automatic test_random_back_to_back();
    out_t got; out_t exp;
    bit mode; int cmd; bit [1:0] iv; int a; int b; bit cin;
    CE = 1'b1;
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom % 2);
      cmd  = int'($urandom % 16);
      iv   = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b11;
      a    = int'($urandom % 256);
      b    = ($urandom % 3 == 0) ? int'($urandom % 8) : int'($urandom % 256);
      cin  = 1'($urandom % 2);
      drive(mode, cmd, iv, a, b, cin);
      tick();
      exp = model(mode, cmd, iv, a, b, cin);
      got = observed();
      if (is_mult(mode, cmd) && !exp.err) begin
        n_cmp++;
        if (got !== '0) begin
          n_bad++; $display("FAIL rand[%0d] mul_stage1 cmd=%0d: got %h want %h", i, cmd, got, 22'h0);
        end
        drive(1'($urandom % 2), int'($urandom % 16), 2'($urandom % 4),
              int'($urandom % 256), int'($urandom % 256), 1'($urandom % 2));
        tick();
        got = observed();
      end
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rand[%0d] mode=%0d cmd=%0d iv=%b a=%0d b=%0d cin=%0d: got %h want %h",
                 i, mode, cmd, iv, a, b, cin, got, exp);
      end
    end
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0);
    test_reset();
    test_directed();
    test_mult();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
